// File: rtl/lime_mem_responder_pkg.sv
// Shared types and constants for the lime memory responder.
// Optional ack watchdog is enabled by defining LIME_MEM_TIMEOUT_EN.
package lime_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lime_mem_state_e;

    typedef enum logic {
        DST_IR  = 1'b0,
        DST_MDR = 1'b1
    } lime_mem_dst_e;

    localparam logic [15:0] LIME_MEM_POISON = 16'hDEAD;

    // True when more than one memory strobe is asserted in the same cycle.
    function automatic logic multi_cmd(input logic mem_r, input logic mem_w, input logic ir_write);
        return (mem_r & mem_w) | (mem_r & ir_write) | (mem_w & ir_write);
    endfunction

endpackage

// File: rtl/lime_mem_responder_if.sv
// SRAM request/response bus between the lime memory responder and the backing SRAM.
interface lime_mem_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_ack;

    modport master (
        output sram_req, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, sram_ack
    );

    modport slave (
        input  sram_req, sram_we, sram_addr, sram_wdata,
        output sram_rdata, sram_ack
    );
endinterface

// File: rtl/lime_mem_watchdog.sv
// Loadable down-counter; expire_c flags the last permitted BUSY cycle.
module lime_mem_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic CLK,
    input  logic Reset,
    input  logic load,
    input  logic run,
    output logic expire_c
);
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(TIMEOUT);
        end else if (run && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Count holds the number of BUSY cycles left including the current one.
    assign expire_c = run && (count_q <= CNT_W'(1));

endmodule

// File: rtl/lime_mem_responder.sv
// Memory-side responder: runs one SRAM transaction per control-unit strobe and loads IR/MDR.
// Define LIME_MEM_TIMEOUT_EN to add the BUSY ack watchdog (poison load on expiry).
module lime_mem_responder
    import lime_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                MemR,
    input  logic                MemW,
    input  logic                IRWrite,
    input  logic                IoD,
    input  logic [ADDR_W-1:0]   PC,
    input  logic [ADDR_W-1:0]   ALUOut,
    input  logic [DATA_W-1:0]   WData,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   IR,
    output logic [DATA_W-1:0]   MDR,
    output logic                proto_err,
    lime_mem_responder_if.master sram
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_BUSY = 2'(BUSY);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]     state_q;
    logic [1:0]     state_d;
    lime_mem_dst_e  dst_q;

    logic any_cmd_c;
    logic capture_c;
    logic complete_c;
    logic timeout_c;
    logic expire_c;
    logic stray_ack_c;

    assign any_cmd_c   = MemR | MemW | IRWrite;
    assign stray_ack_c = sram.sram_ack && (state_q != S_BUSY);

`ifdef LIME_MEM_TIMEOUT_EN
    lime_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK      (CLK),
        .Reset    (Reset),
        .load     (capture_c),
        .run      (state_q == S_BUSY),
        .expire_c (expire_c)
    );
`else
    logic unused_timeout_c;

    assign expire_c         = 1'b0;
    assign unused_timeout_c = ^{32'(TIMEOUT), LIME_MEM_POISON};
`endif

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transaction event decode; ack wins over a same-cycle expiry.
    always_comb begin
        state_d    = state_q;
        capture_c  = 1'b0;
        complete_c = 1'b0;
        timeout_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_cmd_c) begin
                    state_d   = S_BUSY;
                    capture_c = 1'b1;
                end
            end
            S_BUSY: begin
                if (sram.sram_ack) begin
                    state_d    = S_DONE;
                    complete_c = 1'b1;
                end else if (expire_c) begin
                    state_d   = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered handshake outputs follow the next state so they align with it.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mem_ready     <= 1'b0;
            sram.sram_req <= 1'b0;
        end else begin
            mem_ready     <= (state_d == S_DONE);
            sram.sram_req <= (state_d == S_BUSY);
        end
    end

    // Request capture; address and data stay frozen until the next command.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sram.sram_we    <= 1'b0;
            sram.sram_addr  <= '0;
            sram.sram_wdata <= '0;
            dst_q           <= DST_IR;
        end else if (capture_c) begin
            sram.sram_we    <= MemW;
            sram.sram_addr  <= IoD ? ALUOut : PC;
            sram.sram_wdata <= WData;
            dst_q           <= IRWrite ? DST_IR : DST_MDR;
        end
    end

    // Read-data landing registers; writes leave both untouched.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            IR  <= '0;
            MDR <= '0;
        end else if (!sram.sram_we) begin
            if (complete_c) begin
                if (dst_q == DST_IR) begin
                    IR <= sram.sram_rdata;
                end else begin
                    MDR <= sram.sram_rdata;
                end
            end else if (timeout_c) begin
                if (dst_q == DST_IR) begin
                    IR <= DATA_W'(LIME_MEM_POISON);
                end else begin
                    MDR <= DATA_W'(LIME_MEM_POISON);
                end
            end
        end
    end

    // Sticky error: conflicting strobes, ack outside BUSY, or watchdog expiry.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            proto_err <= 1'b0;
        end else if ((capture_c && multi_cmd(MemR, MemW, IRWrite)) || stray_ack_c || timeout_c) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: doc/lime_mem_responder.md
# lime_mem_responder

Memory-side responder for the lime multi-cycle control unit. It accepts the control unit's per-state memory strobes (`MemR`, `MemW`, `IoD`, `IRWrite`), selects the address, runs one transaction to the backing SRAM over a req/ack handshake, and latches the read data into the instruction register (IR) or the memory data register (MDR). It reports completion with a one-cycle `mem_ready` pulse, so the control FSM can stall in memory states for variable-latency memory.

## Interface
- `DATA_W`, 16: data word width.
- `ADDR_W`, 16: word address width.
- `TIMEOUT`, 15: maximum BUSY cycles without `sram_ack`. Used only with `LIME_MEM_TIMEOUT_EN`.

Ports:
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `MemR` in 1: data read request; result goes to MDR.
- `MemW` in 1: data write request.
- `IRWrite` in 1: instruction fetch request; result goes to IR.
- `IoD` in 1: address select. 0 selects `PC`, 1 selects `ALUOut`.
- `PC` in ADDR_W: fetch address.
- `ALUOut` in ADDR_W: data address.
- `WData` in DATA_W: store data.
- `mem_ready` out 1: one-cycle completion pulse.
- `IR` out DATA_W: instruction register.
- `MDR` out DATA_W: memory data register.
- `proto_err` out 1: sticky protocol/timeout error flag.
- `sram_req` out 1, `sram_we` out 1, `sram_addr` out ADDR_W, `sram_wdata` out DATA_W: SRAM request bus.
- `sram_rdata` in DATA_W, `sram_ack` in 1: SRAM response.

## Operation
- FSM states:
  - IDLE: sample commands.
  - BUSY: `sram_req` held high.
  - DONE: `mem_ready`=1.
- IDLE transitions: any of `MemR`/`MemW`/`IRWrite` high at a rising edge moves to BUSY. At that edge, capture:
  - `sram_addr` = `IoD` ? `ALUOut` : `PC`
  - `sram_wdata` = `WData`
  - `sram_we` = `MemW`
  - destination: IR if `IRWrite` is high, else MDR
- Command priority:
  - `MemW` beats reads.
  - `IRWrite` beats `MemR`.
  - More than one strobe high sets `proto_err`; the winning command still executes.
- BUSY → DONE on the edge where `sram_ack` is sampled high.
  - At that same edge, read data loads into the selected register (IR or MDR).
  - Writes load neither register.
- DONE → IDLE unconditionally. Commands present during DONE are ignored. The control unit must leave its memory state on the edge that samples `mem_ready`.
- Address and write data are registered. Changes on `PC`/`ALUOut`/`WData` after capture do not affect the transaction in flight.
- `sram_req`, `sram_we`, `sram_addr` and `sram_wdata` are stable for the whole BUSY period.
- `sram_ack` is ignored outside BUSY. An ack seen outside BUSY sets `proto_err`.
- `proto_err` is cleared only by `Reset`.

## Timing
- Reset values: state IDLE; `mem_ready`, `sram_req`, `sram_we`, `proto_err` all 0; `sram_addr`, `sram_wdata`, `IR`, `MDR` all 0.
- Reset asserted mid-transaction aborts immediately. `sram_req` drops asynchronously and no register is updated.
- Latency: command sampled at edge t; `sram_req` is high from t+1.
  - If ack is high in the first BUSY cycle, `mem_ready` is high in cycle t+2.
  - In general, `mem_ready` is high at t+2+(ack wait cycles).
- Back-to-back minimum: one transaction per 3 cycles (IDLE, BUSY, DONE).
- IR/MDR are valid in the DONE cycle, and hold until the next read to the same register.

## Configuration
- `LIME_MEM_TIMEOUT_EN` defined:
  - A counter runs in BUSY, reset on entry.
  - After `TIMEOUT` cycles without ack, the FSM forces DONE.
  - The target register loads `16'hDEAD`, `proto_err` is set, and `sram_req` drops.
- Undefined: BUSY waits indefinitely, with no counter logic.

## Structure
- Package `lime_mem_pkg`:
  - FSM state enum {IDLE, BUSY, DONE}
  - `LIME_MEM_POISON` = 16'hDEAD
  - destination-select enum {DST_IR, DST_MDR}
- Sub-module `lime_mem_watchdog`: a loadable down-counter with an expire flag. It is instantiated only under `LIME_MEM_TIMEOUT_EN`.

## Test plan
- Fetch: `IRWrite`=1, `IoD`=0, `PC`=16'h0010; SRAM acks 2 cycles after req with 16'h1234.
  - Expect `sram_addr`=16'h0010, `sram_we`=0.
  - `mem_ready` pulses once; IR=16'h1234; MDR unchanged.
- Load: `MemR`=1, `IoD`=1, `ALUOut`=16'h0200; ack in the first BUSY cycle with 16'hBEEF.
  - Expect `mem_ready` at t+2 and MDR=16'hBEEF.
- Store: `MemW`=1, `ALUOut`=16'h0300, `WData`=16'h00AA.
  - Expect `sram_we`=1 and `sram_wdata`=16'h00AA; IR and MDR unchanged.
  - Change `WData` during BUSY: `sram_wdata` stays 16'h00AA.
- Conflict: `MemR` and `MemW` both high → write executes and `proto_err`=1. Commands held through DONE cause no second transaction.
- `Reset` pulsed in BUSY → `sram_req`=0 immediately; state IDLE; IR/MDR=0; `proto_err`=0.
- With `LIME_MEM_TIMEOUT_EN`, `TIMEOUT`=4 and no ack → `mem_ready` after 4 BUSY cycles, MDR=16'hDEAD, `proto_err`=1.
